sdram_rw_controller: RTL and testbench
======================================

SDRAM_RW_CONTROLLER -- requirements
Module: sdram_rw_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ROW_WIDTH 13 row address bits
  COL_WIDTH 9 column address bits
  BANK_WIDTH 2 bank address bits
  DATA_WIDTH 16 data bus bits, multiple of 8
  CLK_FREQUENCY 133 clk in MHz
  REFRESH_COUNT 8192 refreshes per REFRESH_TIME
  REFRESH_TIME 32 refresh period, ms
  CAS_LATENCY 2 CL, 2 or 3
  T_RCD 2 ACT-to-RD/WR cycles, >=1
  T_RP 2 precharge cycles, >=1
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk  in  1  clock; all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  haddr  in  BANK_WIDTH+ROW_WIDTH+COL_WIDTH  host address {bank,row,col}
  data_input  in  DATA_WIDTH  write data
  data_output  out  DATA_WIDTH  read data, registered
  data_valid  out  1  one-cycle pulse, data_output valid
  busy  out  1  high = requests ignored
  rd_enable  in  1  read request
  wr_enable  in  1  write request
  addr  out  max(ROW_WIDTH,COL_WIDTH)  SDRAM A
  bank_addr  out  BANK_WIDTH  SDRAM BA
  data  inout  DATA_WIDTH  SDRAM DQ
  clock_enable  out  1  CKE
  cs_n, ras_n, cas_n, we_n  out  1 each  SDRAM command
  dqm  out  DATA_WIDTH/8  byte masks, 0 = enabled

Function
REQ-003 All SDRAM outputs SHALL be registered; unused cycles SHALL carry NOP.
REQ-004 States SHALL be INIT, IDLE, REFRESH, WRITE, READ; busy SHALL be 0 only in IDLE with no refresh pending.
REQ-005 INIT: INIT_NOP NOPs, PALL(A10=1), T_RP NOPs, REF, T_RFC NOPs, REF, T_RFC NOPs, MRS (A[2:0]=000 BL1, A3=0, A[6:4]=CAS_LATENCY, others 0), T_MRD NOPs, then IDLE.
REQ-006 IDLE priority SHALL be refresh pending > wr_enable > rd_enable; rd_enable and wr_enable together SHALL perform only the write; requests while busy=1 SHALL be dropped.
REQ-007 On acceptance at edge N, haddr/data_input SHALL be latched and ACT(bank,row) driven in cycle N+1; RD/WR with column, A10=1 (auto-precharge) SHALL follow exactly T_RCD cycles after ACT.
REQ-008 Write: DQ driven with latched data and dqm=0 in the WR cycle only; then T_RP+1 NOPs; then IDLE. DQ SHALL be high-Z in all other cycles.
REQ-009 Read: DQ sampled CAS_LATENCY cycles after RD; data_output updated and data_valid pulsed one cycle later; then T_RP NOPs; then IDLE.
REQ-010 Refresh counter SHALL count every cycle, set pending at CYCLES_BETWEEN_REFRESH=(CLK_FREQUENCY*1e6*REFRESH_TIME/1000)/REFRESH_COUNT (integer, 519 default) and clear on entering REFRESH; an in-flight access SHALL complete first.
REQ-011 REFRESH: REF, T_RFC NOPs, IDLE; no PALL needed (auto-precharge).
REQ-012 Wait counter width SHALL be $clog2 of the largest wait+1; no wrap within any wait.

Reset
REQ-013 rst_n=0, including mid-access, SHALL enter INIT: NOP, clock_enable=1, dqm all 1, DQ high-Z, busy=1, data_valid=0, data_output=0, refresh counter=0; full init repeats.

Structure
REQ-014 Package sdram_pkg SHALL hold command encodings {cs_n,ras_n,cas_n,we_n}, state enum, T_RFC=8, T_MRD=2, INIT_NOP=100.
REQ-015 One sub-module sdram_wait_timer (load value, count down, done flag) SHALL time all waits.

Verification
REQ-016 Release reset -> 100 NOPs, PALL, 2xREF spaced T_RFC, MRS addr=0x020 (CL2), busy falls T_MRD+1 cycles after MRS.
REQ-017 Write bank1 row 0x0123 col 0x045 data 0xBEEF -> ACT ba=1 addr=0x0123 next cycle; WR addr=0x445 2 cycles later, DQ=0xBEEF, dqm=00.
REQ-018 Read same address, model drives 0xBEEF CL=2 after RD -> data_output=0xBEEF, data_valid pulse exactly RD+3.
REQ-019 rd_enable and wr_enable high same cycle -> only WR issued, no data_valid.
REQ-020 Refresh expiry (cycle 519) during read -> read completes, then REF, busy high throughout.
REQ-021 rst_n low during WR cycle -> DQ high-Z next cycle, INIT sequence restarts from 100 NOPs.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, controller states and fixed device timings.
package sdram_pkg;

    // SDRAM command bus {cs_n, ras_n, cas_n, we_n}
    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } sdram_cmd_t;

    localparam sdram_cmd_t CMD_NOP  = sdram_cmd_t'(4'b0111);
    localparam sdram_cmd_t CMD_ACT  = sdram_cmd_t'(4'b0011);
    localparam sdram_cmd_t CMD_RD   = sdram_cmd_t'(4'b0101);
    localparam sdram_cmd_t CMD_WR   = sdram_cmd_t'(4'b0100);
    localparam sdram_cmd_t CMD_PALL = sdram_cmd_t'(4'b0010);
    localparam sdram_cmd_t CMD_REF  = sdram_cmd_t'(4'b0001);
    localparam sdram_cmd_t CMD_MRS  = sdram_cmd_t'(4'b0000);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_REFRESH,
        ST_WRITE,
        ST_READ
    } state_t;

    localparam int unsigned T_RFC    = 8;
    localparam int unsigned T_MRD    = 2;
    localparam int unsigned INIT_NOP = 100;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; done_c is high once the loaded count has expired.
module sdram_wait_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; counter parks at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/sdram_rw_controller.sv
// Single-word SDRAM read/write controller with power-up init and periodic auto refresh.
module sdram_rw_controller
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_WIDTH     = 13,
    parameter int unsigned COL_WIDTH     = 9,
    parameter int unsigned BANK_WIDTH    = 2,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CLK_FREQUENCY = 133,
    parameter int unsigned REFRESH_COUNT = 8192,
    parameter int unsigned REFRESH_TIME  = 32,
    parameter int unsigned CAS_LATENCY   = 2,
    parameter int unsigned T_RCD         = 2,
    parameter int unsigned T_RP          = 2,
    localparam int unsigned HADDR_WIDTH  = BANK_WIDTH + ROW_WIDTH + COL_WIDTH,
    localparam int unsigned A_WIDTH      = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    localparam int unsigned DQM_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0]  data_input,
    output logic [DATA_WIDTH-1:0]  data_output,
    output logic                   data_valid,
    output logic                   busy,
    input  logic                   rd_enable,
    input  logic                   wr_enable,
    output logic [A_WIDTH-1:0]     addr,
    output logic [BANK_WIDTH-1:0]  bank_addr,
    inout  wire  [DATA_WIDTH-1:0]  data,
    output logic                   clock_enable,
    output logic                   cs_n,
    output logic                   ras_n,
    output logic                   cas_n,
    output logic                   we_n,
    output logic [DQM_WIDTH-1:0]   dqm
);

    localparam int unsigned CYCLES_BETWEEN_REFRESH =
        (CLK_FREQUENCY * 1000 * REFRESH_TIME) / REFRESH_COUNT;
    localparam int unsigned REF_CNT_WIDTH = $clog2(CYCLES_BETWEEN_REFRESH + 1);
    localparam int unsigned MAX_WAIT = max_u(max_u(INIT_NOP - 1, T_RFC),
                                             max_u(max_u(T_RP + 1, CAS_LATENCY),
                                                   max_u(T_MRD, T_RCD)));
    localparam int unsigned WAIT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [A_WIDTH-1:0] A10_MASK  = A_WIDTH'(1 << 10);
    localparam logic [A_WIDTH-1:0] MRS_VALUE = A_WIDTH'(CAS_LATENCY << 4);

    state_t                   state, state_d;
    logic [2:0]               step, step_d;
    sdram_cmd_t               cmd_q, cmd_d;
    logic [A_WIDTH-1:0]       addr_d;
    logic [BANK_WIDTH-1:0]    bank_d;
    logic [DQM_WIDTH-1:0]     dqm_d;
    logic                     dq_oe, dq_oe_d;
    logic [DATA_WIDTH-1:0]    dq_out, dq_out_d;
    logic                     busy_d;
    logic                     data_valid_d;
    logic [DATA_WIDTH-1:0]    data_output_d;
    logic [BANK_WIDTH-1:0]    lat_bank, lat_bank_d;
    logic [COL_WIDTH-1:0]     lat_col, lat_col_d;
    logic [DATA_WIDTH-1:0]    lat_data, lat_data_d;
    logic [REF_CNT_WIDTH-1:0] ref_cnt;
    logic                     ref_pending, ref_pending_d;
    logic                     ref_expire_c;
    logic                     ref_take;
    logic                     timer_load;
    logic [WAIT_WIDTH-1:0]    timer_value;
    logic                     timer_done;

    sdram_wait_timer #(
        .WIDTH (WAIT_WIDTH)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done_c     (timer_done)
    );

    assign ref_expire_c = (ref_cnt == REF_CNT_WIDTH'(CYCLES_BETWEEN_REFRESH - 1));

    assign cs_n  = cmd_q.cs_n;
    assign ras_n = cmd_q.ras_n;
    assign cas_n = cmd_q.cas_n;
    assign we_n  = cmd_q.we_n;
    assign data  = dq_oe ? dq_out : {DATA_WIDTH{1'bz}};

    // State, command/address/DQ output registers and refresh interval counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            step         <= 3'd0;
            cmd_q        <= CMD_NOP;
            addr         <= '0;
            bank_addr    <= '0;
            dqm          <= '1;
            clock_enable <= 1'b1;
            dq_oe        <= 1'b0;
            dq_out       <= '0;
            busy         <= 1'b1;
            data_valid   <= 1'b0;
            data_output  <= '0;
            lat_bank     <= '0;
            lat_col      <= '0;
            lat_data     <= '0;
            ref_cnt      <= '0;
            ref_pending  <= 1'b0;
        end else begin
            state        <= state_d;
            step         <= step_d;
            cmd_q        <= cmd_d;
            addr         <= addr_d;
            bank_addr    <= bank_d;
            dqm          <= dqm_d;
            clock_enable <= 1'b1;
            dq_oe        <= dq_oe_d;
            dq_out       <= dq_out_d;
            busy         <= busy_d;
            data_valid   <= data_valid_d;
            data_output  <= data_output_d;
            lat_bank     <= lat_bank_d;
            lat_col      <= lat_col_d;
            lat_data     <= lat_data_d;
            ref_cnt      <= ref_expire_c ? '0 : ref_cnt + REF_CNT_WIDTH'(1);
            ref_pending  <= ref_pending_d;
        end
    end

    // Next state and next registered outputs; every command also loads its trailing wait
    always_comb begin
        state_d       = state;
        step_d        = step;
        cmd_d         = CMD_NOP;
        addr_d        = '0;
        bank_d        = '0;
        dq_oe_d       = 1'b0;
        dq_out_d      = dq_out;
        data_valid_d  = 1'b0;
        data_output_d = data_output;
        lat_bank_d    = lat_bank;
        lat_col_d     = lat_col;
        lat_data_d    = lat_data;
        timer_load    = 1'b0;
        timer_value   = '0;
        ref_take      = 1'b0;

        case (state)
            ST_INIT: begin
                case (step)
                    3'd0: begin
                        timer_load  = 1'b1;
                        timer_value = WAIT_WIDTH'(INIT_NOP - 1);
                        step_d      = 3'd1;
                    end
                    3'd1: if (timer_done) begin
                        cmd_d       = CMD_PALL;
                        addr_d      = A10_MASK;
                        timer_load  = 1'b1;
                        timer_value = WAIT_WIDTH'(T_RP);
                        step_d      = 3'd2;
                    end
                    3'd2, 3'd3: if (timer_done) begin
                        cmd_d       = CMD_REF;
                        timer_load  = 1'b1;
                        timer_value = WAIT_WIDTH'(T_RFC);
                        step_d      = step + 3'd1;
                    end
                    3'd4: if (timer_done) begin
                        cmd_d       = CMD_MRS;
                        addr_d      = MRS_VALUE;
                        timer_load  = 1'b1;
                        timer_value = WAIT_WIDTH'(T_MRD);
                        step_d      = 3'd5;
                    end
                    default: if (timer_done) begin
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                    end
                endcase
            end
            ST_IDLE: begin
                if (ref_pending) begin
                    cmd_d       = CMD_REF;
                    timer_load  = 1'b1;
                    timer_value = WAIT_WIDTH'(T_RFC);
                    ref_take    = 1'b1;
                    state_d     = ST_REFRESH;
                end else if (wr_enable || rd_enable) begin
                    lat_bank_d  = haddr[HADDR_WIDTH-1 -: BANK_WIDTH];
                    lat_col_d   = haddr[COL_WIDTH-1:0];
                    lat_data_d  = data_input;
                    cmd_d       = CMD_ACT;
                    bank_d      = haddr[HADDR_WIDTH-1 -: BANK_WIDTH];
                    addr_d      = A_WIDTH'(haddr[COL_WIDTH +: ROW_WIDTH]);
                    timer_load  = 1'b1;
                    timer_value = WAIT_WIDTH'(T_RCD - 1);
                    step_d      = 3'd0;
                    state_d     = wr_enable ? ST_WRITE : ST_READ;
                end
            end
            ST_REFRESH: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (timer_done) begin
                    if (step == 3'd0) begin
                        cmd_d       = CMD_WR;
                        bank_d      = lat_bank;
                        addr_d      = A_WIDTH'(lat_col) | A10_MASK;
                        dq_oe_d     = 1'b1;
                        dq_out_d    = lat_data;
                        timer_load  = 1'b1;
                        timer_value = WAIT_WIDTH'(T_RP + 1);
                        step_d      = 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                    end
                end
            end
            ST_READ: begin
                if (timer_done) begin
                    case (step)
                        3'd0: begin
                            cmd_d       = CMD_RD;
                            bank_d      = lat_bank;
                            addr_d      = A_WIDTH'(lat_col) | A10_MASK;
                            timer_load  = 1'b1;
                            timer_value = WAIT_WIDTH'(CAS_LATENCY);
                            step_d      = 3'd1;
                        end
                        3'd1: begin
                            data_output_d = data;
                            data_valid_d  = 1'b1;
                            timer_load    = 1'b1;
                            timer_value   = WAIT_WIDTH'(T_RP);
                            step_d        = 3'd2;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            step_d  = 3'd0;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_INIT;
                step_d  = 3'd0;
            end
        endcase

        ref_pending_d = ref_expire_c | (ref_pending & ~ref_take);
        busy_d        = !((state_d == ST_IDLE) && !ref_pending_d);
        dqm_d         = (state_d == ST_INIT) ? '1 : '0;
    end

endmodule

// File: tb/tb_sdram_rw_controller.sv
// Directed bench for sdram_rw_controller with a minimal SDRAM read-data model.
module tb_sdram_rw_controller;

    localparam int CL         = 2;
    localparam int TB_T_RCD   = 2;
    localparam int TB_T_RP    = 2;
    localparam int TB_T_RFC   = 8;
    localparam int TB_T_MRD   = 2;
    localparam int TB_INITNOP = 100;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PALL = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] haddr = '0;
    logic [15:0] data_input = '0;
    logic [15:0] data_output;
    logic        data_valid;
    logic        busy;
    logic        rd_enable = 1'b0;
    logic        wr_enable = 1'b0;
    logic [12:0] addr;
    logic [1:0]  bank_addr;
    wire  [15:0] data;
    logic        clock_enable;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  dqm;

    logic        tb_drv = 1'b0;
    logic [15:0] model_rdata = '0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    wire [3:0] cmd = {cs_n, ras_n, cas_n, we_n};
    assign data = tb_drv ? model_rdata : 16'hzzzz;

    sdram_rw_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .haddr        (haddr),
        .data_input   (data_input),
        .data_output  (data_output),
        .data_valid   (data_valid),
        .busy         (busy),
        .rd_enable    (rd_enable),
        .wr_enable    (wr_enable),
        .addr         (addr),
        .bank_addr    (bank_addr),
        .data         (data),
        .clock_enable (clock_enable),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .dqm          (dqm)
    );

    always #5 clk = ~clk;

    // Cycle index: equals k during the cycle following the k-th edge after reset release
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // SDRAM read model: drives model_rdata during the CL-th cycle after an RD command
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt <= 0;
            tb_drv <= 1'b0;
        end else begin
            tb_drv <= (rd_cnt == CL);
            if (cmd == C_RD)                   rd_cnt <= 1;
            else if (rd_cnt != 0 && rd_cnt <= CL) rd_cnt <= rd_cnt + 1;
            else                               rd_cnt <= 0;
        end
    end

    task automatic wait_cmd(output int gap, output logic [3:0] c);
        gap = 0;
        c   = 4'hF;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd !== C_NOP) begin
                c = cmd;
                return;
            end
            gap++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd !== C_NOP) begin n_fail++; $display("FAIL reset_cmd: got %h expected %h", cmd, C_NOP); end
        n_cmp++;
        if (clock_enable !== 1'b1) begin n_fail++; $display("FAIL reset_cke: got %b expected 1", clock_enable); end
        n_cmp++;
        if (dqm !== 2'b11) begin n_fail++; $display("FAIL reset_dqm: got %b expected 11", dqm); end
        n_cmp++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_valid: got %b%b expected 10", busy, data_valid);
        end
        n_cmp++;
        if (data_output !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", data_output); end
        n_cmp++;
        if (dut.dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_hiz: got oe=%b expected 0", dut.dq_oe); end
    endtask

    task automatic test_init();
        int g;
        int n;
        logic [3:0] c;
        rst_n = 1'b1;
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_INITNOP || c !== C_PALL || addr[10] !== 1'b1) begin
            n_fail++; $display("FAIL init_pall: got gap=%0d cmd=%h a10=%b expected gap=%0d cmd=%h a10=1", g, c, addr[10], TB_INITNOP, C_PALL);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_T_RP || c !== C_REF) begin
            n_fail++; $display("FAIL init_ref1: got gap=%0d cmd=%h expected gap=%0d cmd=%h", g, c, TB_T_RP, C_REF);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_T_RFC || c !== C_REF) begin
            n_fail++; $display("FAIL init_ref2: got gap=%0d cmd=%h expected gap=%0d cmd=%h", g, c, TB_T_RFC, C_REF);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_T_RFC || c !== C_MRS || addr !== 13'h0020) begin
            n_fail++; $display("FAIL init_mrs: got gap=%0d cmd=%h addr=%h expected gap=%0d cmd=%h addr=0020", g, c, addr, TB_T_RFC, C_MRS);
        end
        wait_idle(n);
        n_cmp++;
        if (n !== TB_T_MRD + 1) begin n_fail++; $display("FAIL init_busy_fall: got %0d expected %0d", n, TB_T_MRD + 1); end
        n_cmp++;
        if (dqm !== 2'b00) begin n_fail++; $display("FAIL idle_dqm: got %b expected 00", dqm); end
    endtask

    task automatic test_write();
        int g;
        int n;
        logic [3:0] c;
        haddr      = {2'd1, 13'h0123, 9'h045};
        data_input = 16'hBEEF;
        wr_enable  = 1'b1;
        @(negedge clk);
        wr_enable  = 1'b0;
        data_input = 16'h0000;
        n_cmp++;
        if (cmd !== C_ACT || bank_addr !== 2'd1 || addr !== 13'h0123) begin
            n_fail++; $display("FAIL wr_act: got cmd=%h ba=%0d addr=%h expected cmd=%h ba=1 addr=0123", cmd, bank_addr, addr, C_ACT);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_T_RCD - 1 || c !== C_WR || addr !== 13'h0445 || bank_addr !== 2'd1) begin
            n_fail++; $display("FAIL wr_cmd: got gap=%0d cmd=%h ba=%0d addr=%h expected gap=%0d cmd=%h ba=1 addr=0445", g, c, bank_addr, addr, TB_T_RCD - 1, C_WR);
        end
        n_cmp++;
        if (data !== 16'hBEEF || dqm !== 2'b00) begin
            n_fail++; $display("FAIL wr_dq: got dq=%h dqm=%b expected dq=beef dqm=00", data, dqm);
        end
        @(negedge clk);
        n_cmp++;
        if (dut.dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_dq_release: got oe=%b expected 0", dut.dq_oe); end
        wait_idle(n);
        n_cmp++;
        if (n !== TB_T_RP + 1) begin n_fail++; $display("FAIL wr_recovery: got %0d expected %0d", n + 1, TB_T_RP + 2); end
    endtask

    task automatic test_read();
        int g;
        int n;
        logic [3:0] c;
        haddr       = {2'd1, 13'h0123, 9'h045};
        model_rdata = 16'hBEEF;
        rd_enable   = 1'b1;
        @(negedge clk);
        rd_enable   = 1'b0;
        n_cmp++;
        if (cmd !== C_ACT || bank_addr !== 2'd1 || addr !== 13'h0123) begin
            n_fail++; $display("FAIL rd_act: got cmd=%h ba=%0d addr=%h expected cmd=%h ba=1 addr=0123", cmd, bank_addr, addr, C_ACT);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_T_RCD - 1 || c !== C_RD || addr !== 13'h0445) begin
            n_fail++; $display("FAIL rd_cmd: got gap=%0d cmd=%h addr=%h expected gap=%0d cmd=%h addr=0445", g, c, addr, TB_T_RCD - 1, C_RD);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_early: got %b expected 0", data_valid); end
        @(negedge clk);
        n_cmp++;
        if (data_valid !== 1'b1 || data_output !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_data: got valid=%b dout=%h expected valid=1 dout=beef", data_valid, data_output);
        end
        @(negedge clk);
        n_cmp++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %b expected 0", data_valid); end
        wait_idle(n);
        n_cmp++;
        if (n !== TB_T_RP) begin n_fail++; $display("FAIL rd_recovery: got %0d expected %0d", n, TB_T_RP); end
    endtask

    task automatic test_both();
        int g;
        int extra;
        int valids;
        logic [3:0] c;
        haddr      = {2'd2, 13'h0001, 9'h010};
        data_input = 16'h1234;
        rd_enable  = 1'b1;
        wr_enable  = 1'b1;
        @(negedge clk);
        rd_enable  = 1'b0;
        wr_enable  = 1'b0;
        n_cmp++;
        if (cmd !== C_ACT || bank_addr !== 2'd2 || addr !== 13'h0001) begin
            n_fail++; $display("FAIL both_act: got cmd=%h ba=%0d addr=%h expected cmd=%h ba=2 addr=0001", cmd, bank_addr, addr, C_ACT);
        end
        wait_cmd(g, c);
        n_cmp++;
        if (c !== C_WR || addr !== 13'h0410 || data !== 16'h1234) begin
            n_fail++; $display("FAIL both_wr: got cmd=%h addr=%h dq=%h expected cmd=%h addr=0410 dq=1234", c, addr, data, C_WR);
        end
        extra  = 0;
        valids = 0;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
            @(negedge clk);
            if (cmd !== C_NOP) extra++;
            if (data_valid !== 1'b0) valids++;
        end
        n_cmp++;
        if (extra !== 0 || valids !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL both_only_write: got cmds=%0d valids=%0d busy=%b expected 0 0 0", extra, valids, busy);
        end
    endtask

    task automatic test_refresh_during_read();
        int busy_low;
        int valid_cyc;
        int ref_cyc;
        int extra;
        logic [15:0] got_dout;
        n_cmp++;
        if (cyc >= 515) begin n_fail++; $display("FAIL refr_setup: got cycle %0d expected below 515", cyc); end
        while (cyc < 515) @(negedge clk);
        haddr       = {2'd1, 13'h0123, 9'h045};
        model_rdata = 16'hBEEF;
        rd_enable   = 1'b1;
        @(negedge clk);
        rd_enable   = 1'b0;
        busy_low  = 0;
        valid_cyc = -1;
        ref_cyc   = -1;
        got_dout  = '0;
        for (int i = 0; i < 40 && ref_cyc < 0; i++) begin
            if (busy !== 1'b1) busy_low++;
            if (data_valid === 1'b1) begin valid_cyc = cyc; got_dout = data_output; end
            if (cmd === C_REF) ref_cyc = cyc;
            else @(negedge clk);
        end
        n_cmp++;
        if (valid_cyc !== 521 || got_dout !== 16'hBEEF) begin
            n_fail++; $display("FAIL refr_read_done: got cycle=%0d dout=%h expected cycle=521 dout=beef", valid_cyc, got_dout);
        end
        n_cmp++;
        if (ref_cyc !== 525) begin n_fail++; $display("FAIL refr_ref_cycle: got %0d expected 525", ref_cyc); end
        n_cmp++;
        if (busy_low !== 0) begin n_fail++; $display("FAIL refr_busy_held: got %0d low cycles expected 0", busy_low); end
        @(negedge clk);
        rd_enable = 1'b1;
        @(negedge clk);
        rd_enable = 1'b0;
        extra = 0;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
            if (cmd !== C_NOP) extra++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc !== 525 + TB_T_RFC + 1 || extra !== 0) begin
            n_fail++; $display("FAIL refr_end: got idle cycle=%0d cmds=%0d expected %0d 0", cyc, extra, 525 + TB_T_RFC + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd !== C_NOP) begin n_fail++; $display("FAIL refr_drop_busy_req: got %h expected %h", cmd, C_NOP); end
    endtask

    task automatic test_reset_mid_write();
        int g;
        logic [3:0] c;
        haddr      = {2'd0, 13'h0002, 9'h003};
        data_input = 16'h5A5A;
        wr_enable  = 1'b1;
        @(negedge clk);
        wr_enable  = 1'b0;
        wait_cmd(g, c);
        n_cmp++;
        if (c !== C_WR || data !== 16'h5A5A) begin
            n_fail++; $display("FAIL rst_wr_setup: got cmd=%h dq=%h expected cmd=%h dq=5a5a", c, data, C_WR);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut.dq_oe !== 1'b0 || cmd !== C_NOP || busy !== 1'b1 || dqm !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_wr: got oe=%b cmd=%h busy=%b dqm=%b expected 0 %h 1 11", dut.dq_oe, cmd, busy, dqm, C_NOP);
        end
        n_cmp++;
        if (data_output !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_dout: got %h expected 0000", data_output); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cmd(g, c);
        n_cmp++;
        if (g !== TB_INITNOP || c !== C_PALL) begin
            n_fail++; $display("FAIL rst_reinit: got gap=%0d cmd=%h expected gap=%0d cmd=%h", g, c, TB_INITNOP, C_PALL);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read();
        test_both();
        test_refresh_during_read();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
